// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the block-RAM port A arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    S_CPU = 2'b00,
    S_LD  = 2'b01,
    S_RET = 2'b10
  } arb_state_e;

  localparam logic [3:0] WE_READ = 4'b0000;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Port-A request/response bundle shared by the CPU, the UART loader and the RAMs.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
);
  logic              cpu_req;
  logic [3:0]        cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_imem;
  logic              ld_req;
  logic [3:0]        ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_imem;
  logic [DATA_W-1:0] mem_douta;
  logic              Stall;
  logic              ld_gnt;
  logic              ld_rvalid;
  logic [DATA_W-1:0] ld_rdata;
  logic              ld_err;
  logic              ena_imem;
  logic              ena_dmem;
  logic [3:0]        wea;
  logic [ADDR_W-1:0] addra;
  logic [DATA_W-1:0] dina;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_imem,
    input  ld_req, ld_we, ld_addr, ld_wdata, ld_imem, mem_douta,
    output Stall, ld_gnt, ld_rvalid, ld_rdata, ld_err,
    output ena_imem, ena_dmem, wea, addra, dina
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_imem,
    output ld_req, ld_we, ld_addr, ld_wdata, ld_imem, mem_douta,
    input  Stall, ld_gnt, ld_rvalid, ld_rdata, ld_err,
    input  ena_imem, ena_dmem, wea, addra, dina
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares IMEM/DMEM port A between the CPU (default owner) and the UART loader,
// stalling the pipeline for the length of each loader burst.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 16,
  parameter int unsigned BURST_MAX    = 8
) (
  input  logic              CLK,
  input  logic              reset,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned WAIT_W = $clog2(STARVE_LIMIT) + 1;
  localparam int unsigned BEAT_W = $clog2(BURST_MAX) + 1;

  arb_state_e        state;
  logic [WAIT_W-1:0] wait_cnt;
  logic [BEAT_W-1:0] beat_cnt;
  logic              ld_rvalid_q;
  logic              ld_err_q;
  logic              rd_beat;
  logic              port_req;
  logic              port_imem;
  logic [3:0]        port_we;

  assign rd_beat = (state == S_LD) && bus.ld_req && (bus.ld_we == WE_READ);

  // Arbitration FSM, starvation/beat counters and the one-cycle read-return flags.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state       <= S_CPU;
      wait_cnt    <= '0;
      beat_cnt    <= '0;
      ld_rvalid_q <= 1'b0;
      ld_err_q    <= 1'b0;
    end else begin
      ld_rvalid_q <= rd_beat && !bus.ld_imem;
      ld_err_q    <= rd_beat && bus.ld_imem;
      case (state)
        S_CPU: begin
          if (bus.ld_req && (!bus.cpu_req || wait_cnt >= WAIT_W'(STARVE_LIMIT))) begin
            state    <= S_LD;
            wait_cnt <= '0;
            beat_cnt <= '0;
          end else if (bus.ld_req) begin
            if (wait_cnt < WAIT_W'(STARVE_LIMIT)) wait_cnt <= wait_cnt + WAIT_W'(1);
          end else begin
            wait_cnt <= '0;
          end
        end
        S_LD: begin
          if (bus.ld_req) beat_cnt <= beat_cnt + BEAT_W'(1);
          // The final beat is still accepted in the cycle that ends the burst.
          if (!bus.ld_req || beat_cnt == BEAT_W'(BURST_MAX - 1)) state <= S_RET;
        end
        S_RET:   state <= S_CPU;
        default: state <= S_CPU;
      endcase
    end
  end

  // Port-A source mux; the S_RET gap keeps both RAMs disabled.
  always_comb begin
    port_req  = 1'b0;
    port_imem = 1'b0;
    port_we   = WE_READ;
    bus.addra = bus.cpu_addr;
    bus.dina  = bus.cpu_wdata;
    case (state)
      S_CPU: begin
        port_req  = bus.cpu_req;
        port_imem = bus.cpu_imem;
        port_we   = bus.cpu_we;
      end
      S_LD: begin
        port_req  = bus.ld_req;
        port_imem = bus.ld_imem;
        port_we   = bus.ld_we;
        bus.addra = bus.ld_addr;
        bus.dina  = bus.ld_wdata;
      end
      default: begin
        bus.addra = bus.ld_addr;
        bus.dina  = bus.ld_wdata;
      end
    endcase
  end

  assign bus.ena_imem  = port_req & port_imem;
  assign bus.ena_dmem  = port_req & ~port_imem;
  assign bus.wea       = port_we & {4{port_req}};
  assign bus.Stall     = (state != S_CPU);
  assign bus.ld_gnt    = (state == S_LD) & bus.ld_req;
  assign bus.ld_rvalid = ld_rvalid_q;
  assign bus.ld_err    = ld_err_q;
  assign bus.ld_rdata  = bus.mem_douta;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized and directed bench for mem_port_arbiter with a transaction-level
// ownership model and a read-response scoreboard.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned DATA_W = 32;
  localparam int STARVE = 16;
  localparam int BURST  = 8;

  typedef struct {
    logic [3:0]        we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              imem;
  } beat_t;

  typedef struct {
    logic              err;
    logic [DATA_W-1:0] data;
    int                due;
  } resp_t;

  logic CLK = 1'b0;
  logic reset;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(.STARVE_LIMIT(STARVE), .BURST_MAX(BURST)) dut (
    .CLK   (CLK),
    .reset (reset),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  beat_t ldq[$];
  resp_t sbq[$];
  resp_t mon_r;
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    g;
  int    naccepted;
  bit    drop;
  bit    acc;
  logic  dut_gnt_s;

  // Reference model: who owns the port, the one-cycle hand-back gap, loader wait and beats taken.
  bit    m_owner, m_gap;
  int    m_wait, m_beats;

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return DATA_W'({a, 8'h5A, ~a});
  endfunction

  always @(posedge CLK) cyc <= cyc + 1;

  // DMEM stand-in with fixed, address-derived contents and one-cycle read latency.
  always @(posedge CLK) if (bus.ena_dmem) bus.mem_douta <= mem_word(bus.addra);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_owner = 1'b0;
    m_gap   = 1'b0;
    m_wait  = 0;
    m_beats = 0;
  endtask

  task automatic push_beats(input int n, input int mode, input logic [ADDR_W-1:0] base);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.addr  = base + ADDR_W'(i);
      b.wdata = $urandom;
      case (mode)
        1:       begin b.we = 4'h0; b.imem = 1'b0; end
        2:       begin b.we = 4'hF; b.imem = 1'b0; end
        3:       begin b.we = 4'h0; b.imem = 1'b1; end
        default: begin
          b.we   = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
          b.imem = ($urandom_range(0, 3) == 0);
          b.addr = ADDR_W'($urandom);
        end
      endcase
      ldq.push_back(b);
    end
  endtask

  // One clock cycle: drive loader, predict outputs, compare at negedge, advance the model.
  task automatic tick();
    logic [49:0] ep;
    logic        e_stall, e_gnt;
    if (ldq.size() > 0 && !drop) begin
      bus.ld_req   = 1'b1;
      bus.ld_we    = ldq[0].we;
      bus.ld_addr  = ldq[0].addr;
      bus.ld_wdata = ldq[0].wdata;
      bus.ld_imem  = ldq[0].imem;
    end else begin
      bus.ld_req = 1'b0;
    end
    e_stall = m_owner || m_gap;
    e_gnt   = m_owner && bus.ld_req;
    if (m_owner)
      ep = {bus.ld_req & bus.ld_imem, bus.ld_req & ~bus.ld_imem, bus.ld_we & {4{bus.ld_req}},
            bus.ld_addr, bus.ld_wdata};
    else
      ep = {bus.cpu_req & bus.cpu_imem, bus.cpu_req & ~bus.cpu_imem, bus.cpu_we & {4{bus.cpu_req}},
            bus.cpu_addr, bus.cpu_wdata};
    @(negedge CLK);
    dut_gnt_s = bus.ld_gnt;
    chk("stall", 64'(bus.Stall), 64'(e_stall));
    chk("ld_gnt", 64'(bus.ld_gnt), 64'(e_gnt));
    if (m_gap)
      chk("gap_enables", 64'({bus.ena_imem, bus.ena_dmem}), 64'(0));
    else
      chk("port", 64'({bus.ena_imem, bus.ena_dmem, bus.wea, bus.addra, bus.dina}), 64'(ep));
    acc = m_owner && bus.ld_req;
    if (acc && bus.ld_we == WE_READ)
      sbq.push_back('{err: bus.ld_imem, data: mem_word(bus.ld_addr), due: cyc + 1});
    @(posedge CLK);
    if (m_gap) begin
      m_gap = 1'b0;
    end else if (m_owner) begin
      if (bus.ld_req) m_beats++;
      if (!bus.ld_req || m_beats == BURST) begin
        m_owner = 1'b0;
        m_gap   = 1'b1;
      end
    end else if (bus.ld_req && (!bus.cpu_req || m_wait >= STARVE)) begin
      m_owner = 1'b1;
      m_wait  = 0;
      m_beats = 0;
    end else if (bus.ld_req) begin
      if (m_wait < STARVE) m_wait++;
    end else begin
      m_wait = 0;
    end
    if (acc) void'(ldq.pop_front());
    #1;
  endtask

  task automatic run_loader(input int max_cyc, output int first_gnt);
    first_gnt = 0;
    for (int k = 1; k <= max_cyc; k++) begin
      tick();
      if (dut_gnt_s && first_gnt == 0) first_gnt = k;
      if (ldq.size() == 0 && !m_owner && !m_gap) return;
    end
    checks++;
    errors++;
    $display("FAIL run_loader: loader queue not drained after %0d cycles (left %0d)", max_cyc, ldq.size());
  endtask

  // Scoreboard monitor: every read return must match the oldest expected response.
  always @(negedge CLK) begin
    if (!reset) begin
      if (bus.ld_rvalid || bus.ld_err) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL resp_unexpected: rvalid=%0b err=%0b expected none (cycle %0d)",
                   bus.ld_rvalid, bus.ld_err, cyc);
        end else begin
          mon_r = sbq.pop_front();
          chk("resp_kind", 64'({bus.ld_rvalid, bus.ld_err}), 64'({~mon_r.err, mon_r.err}));
          chk("resp_cycle", 64'(cyc), 64'(mon_r.due));
          if (!mon_r.err) chk("ld_rdata", 64'(bus.ld_rdata), 64'(mon_r.data));
        end
      end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
        mon_r = sbq.pop_front();
        checks++;
        errors++;
        $display("FAIL resp_missing: got no response expected err=%0b due cycle %0d (cycle %0d)",
                 mon_r.err, mon_r.due, cyc);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset         = 1'b1;
    drop          = 1'b0;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 4'h0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.cpu_imem  = 1'b0;
    bus.ld_req    = 1'b0;
    bus.ld_we     = 4'h0;
    bus.ld_addr   = '0;
    bus.ld_wdata  = '0;
    bus.ld_imem   = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_out", 64'({bus.Stall, bus.ld_gnt, bus.ld_rvalid, bus.ld_err}), 64'(0));
    @(negedge CLK) reset = 1'b0;
    @(posedge CLK);
    #1;

    // Single loader write to DMEM 0x010 while the CPU is idle.
    push_beats(1, 2, 12'h010);
    run_loader(40, g);
    chk("t1_latency", 64'(g), 64'(2));

    // CPU busy: loader must wait out the starvation limit.
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 4'h3;
    bus.cpu_addr  = 12'h123;
    bus.cpu_wdata = 32'hDEAD_BEEF;
    push_beats(1, 2, 12'h200);
    run_loader(60, g);
    chk("t2_starve", 64'(g), 64'(STARVE + 2));
    bus.cpu_req = 1'b0;

    // Ten DMEM reads: one full burst, hand-back, then re-grant for the rest.
    push_beats(10, 1, 12'h300);
    run_loader(80, g);
    chk("t3_latency", 64'(g), 64'(2));

    // Simultaneous requests with no accumulated wait: the CPU wins.
    bus.cpu_req = 1'b1;
    push_beats(1, 2, 12'h040);
    tick();
    chk("t4_tie", 64'(dut_gnt_s), 64'(0));
    bus.cpu_req = 1'b0;
    run_loader(40, g);

    // IMEM read is rejected with an error pulse.
    push_beats(1, 3, 12'h055);
    run_loader(40, g);
    repeat (2) tick();

    // Reset in the middle of a burst, right after the third read beat.
    push_beats(6, 1, 12'h600);
    naccepted = 0;
    for (int k = 0; k < 40 && naccepted < 3; k++) begin
      tick();
      if (acc) naccepted++;
    end
    chk("t6_beats", 64'(naccepted), 64'(3));
    reset = 1'b1;
    #1;
    chk("t6_reset_out", 64'({bus.Stall, bus.ld_gnt, bus.ena_imem, bus.ena_dmem, bus.ld_rvalid, bus.ld_err}),
        64'(0));
    ldq.delete();
    sbq.delete();
    bus.ld_req = 1'b0;
    model_reset();
    @(negedge CLK) reset = 1'b0;
    @(posedge CLK);
    #1;
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = 4'hF;
    bus.cpu_imem  = 1'b0;
    bus.cpu_addr  = 12'h0AA;
    bus.cpu_wdata = 32'h1234_5678;
    tick();
    chk("t6_cpu_store", 64'({bus.ena_dmem, bus.wea}), 64'({1'b1, 4'hF}));
    bus.cpu_req = 1'b0;

    // Randomized traffic from both masters.
    for (int n = 0; n < 1500; n++) begin
      if (!(m_owner || m_gap)) begin
        bus.cpu_req   = ($urandom_range(0, 9) < 6);
        bus.cpu_we    = 4'($urandom);
        bus.cpu_addr  = ADDR_W'($urandom);
        bus.cpu_wdata = $urandom;
        bus.cpu_imem  = 1'($urandom);
      end
      if (ldq.size() == 0 && $urandom_range(0, 5) == 0)
        push_beats($urandom_range(1, 12), 0, '0);
      drop = ($urandom_range(0, 7) == 0);
      tick();
    end
    drop = 1'b0;
    bus.cpu_req = 1'b0;
    run_loader(200, g);
    repeat (3) tick();
    chk("drain", 64'(sbq.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
